div: RTL

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 44 ++++
 rtl/div.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the iterative divider: FSM state
//                encoding, ready/start handshake constants, the EX-stage
//                aluop codes that select DIV/DIVU, and an operand magnitude
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Divider FSM state encoding
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Handshake constants shared with the EX stage
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // aluop codes decoded by EX to raise start_i / signed_div_i
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Number of shift-subtract iterations for a 32-bit quotient
  localparam logic [5:0] DIV_STEPS = 6'd32;

  // Magnitude of a 32-bit operand; only negates when the operation is signed.
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] value,
                                        input logic        is_signed);
    if (is_signed && value[31]) begin
      return 32'd0 - value;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module      : div
//  Description : Multi-cycle 32-bit restoring divider for the EX stage.
//                Signed (DIV) and unsigned (DIVU) division, 32 iterations
//                on a 65-bit working register, with divide-by-zero shortcut.
//                Optional build macro DIV_EARLY_OUT_EN: skips the iterations
//                when |dividend| < |divisor|.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous active-high reset
//                signed_div_i - 1 = signed DIV, 0 = unsigned DIVU
//                opdata1_i    - dividend
//                opdata2_i    - divisor
//                start_i      - division request (hold until result taken)
//                annul_i      - abort (flush / exception), beats start_i
//                result_o     - {remainder, quotient}
//                ready_o      - result_o valid
//                stallreq_o   - pipeline stall request
//  Revision    : 1.0 - initial release
// ============================================================================
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  // Counter value during the final iteration
  localparam logic [5:0] c_last_step = DIV_STEPS - 6'd1;

  div_state_t  r_state;
  logic [5:0]  r_cnt;
  // [64:32] partial remainder, [31:0] dividend bits shifting into quotient
  logic [64:0] r_work;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
`ifdef DIV_EARLY_OUT_EN
  logic        r_early;
  logic [31:0] r_dividend;
`endif

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [33:0] w_trial;
  logic [64:0] w_next;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_abs_a = abs32(opdata1_i, signed_div_i);
  assign w_abs_b = abs32(opdata2_i, signed_div_i);

  // One restoring step: shift left by one, then try to subtract the divisor
  // from the upper 33 bits. Bit 64 of the register is always zero between
  // steps, so the top bit of the 34-bit difference is a clean borrow flag.
  assign w_trial = r_work[64:31] - {2'b00, r_divisor};
  assign w_next  = w_trial[33] ? {r_work[63:0], 1'b0}
                               : {w_trial[32:0], r_work[30:0], 1'b1};

  assign w_quo     = w_next[31:0];
  assign w_rem     = w_next[63:32];
  assign w_quo_fix = r_neg_q ? (32'd0 - w_quo) : w_quo;
  assign w_rem_fix = r_neg_r ? (32'd0 - w_rem) : w_rem;

  assign stallreq_o = start_i & ~ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= 6'd0;
      r_work     <= 65'd0;
      r_divisor  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      result_o   <= 64'd0;
      ready_o    <= DIV_RESULT_NOT_READY;
`ifdef DIV_EARLY_OUT_EN
      r_early    <= 1'b0;
      r_dividend <= 32'd0;
`endif
    end else if (annul_i) begin
      r_state  <= DIV_FREE;
      r_cnt    <= 6'd0;
      result_o <= 64'd0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (start_i == DIV_START) begin
            r_divisor <= w_abs_b;
            r_work    <= {33'd0, w_abs_a};
            r_cnt     <= 6'd0;
            // Quotient negative when signs differ; remainder follows dividend
            r_neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_r   <= signed_div_i & opdata1_i[31];
`ifdef DIV_EARLY_OUT_EN
            r_dividend <= opdata1_i;
            r_early    <= (w_abs_a < w_abs_b);
`endif
            if (opdata2_i == 32'd0) begin
              r_state <= DIV_BY_ZERO;
            end else begin
              r_state <= DIV_ON;
            end
          end
        end

        DIV_BY_ZERO: begin
          r_state  <= DIV_END;
          result_o <= 64'd0;
          ready_o  <= DIV_RESULT_READY;
        end

        DIV_ON: begin
`ifdef DIV_EARLY_OUT_EN
          // Short path spends a single DIV_ON cycle so its result appears
          // with the same latency as the divide-by-zero path.
          if (r_early) begin
            r_state  <= DIV_END;
            result_o <= {r_dividend, 32'd0};
            ready_o  <= DIV_RESULT_READY;
            r_early  <= 1'b0;
          end else begin
`endif
            r_work <= w_next;
            r_cnt  <= r_cnt + 6'd1;
            if (r_cnt == c_last_step) begin
              r_state  <= DIV_END;
              result_o <= {w_rem_fix, w_quo_fix};
              ready_o  <= DIV_RESULT_READY;
            end
`ifdef DIV_EARLY_OUT_EN
          end
`endif
        end

        DIV_END: begin
          // Result stays on the bus until EX drops the request
          if (start_i == DIV_STOP) begin
            r_state  <= DIV_FREE;
            result_o <= 64'd0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end

        default: begin
          r_state <= DIV_FREE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
